// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
// Frame geometry and launch latency set the WAIT reload value.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned LAUNCH_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // WAIT ends exactly LAUNCH_LAT cycles before the next start bit may begin.
  function automatic logic [4:0] wait_reload(input int unsigned gap);
    return 5'(FRAME_BITS - LAUNCH_LAT + gap);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or above
// ptr wins, wrapping back to index 0.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         win,
  output logic                     any
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned IW = PW + 1;

  logic [IW-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + IW'(i);
      if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
      if (!any && req[idx[PW-1:0]]) begin
        win[idx[PW-1:0]] = 1'b1;
        any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one sender UART between N_REQ byte producers;
// issues the start pulse and reserves the line for the frame plus GAP idle bits.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               start,
  output logic [8:1]         message
);

  localparam int unsigned PW     = $clog2(N_REQ);
  localparam logic [4:0]  RELOAD = wait_reload(GAP);

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n, nxt_ptr;
  logic [4:0]       cnt, cnt_n;
  logic [N_REQ-1:0] win, grant_n;
  logic             any, start_n;
  logic [7:0]       sel_byte, msg_n;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // One-hot winner to captured byte and next pointer.
  always_comb begin
    sel_byte = '0;
    nxt_ptr  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        sel_byte = sel_byte | data[8*i +: 8];
        nxt_ptr  = PW'((i + 1) % N_REQ);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (any) state_n = ST_LAUNCH;
      ST_LAUNCH: state_n = ST_WAIT;
      ST_WAIT:   if (cnt == '0) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    start_n = 1'b1;
    grant_n = '0;
    msg_n   = message;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (any) begin
          start_n = 1'b0;
          grant_n = win;
          msg_n   = sel_byte;
          ptr_n   = nxt_ptr;
        end
      end
      ST_LAUNCH: cnt_n = RELOAD;
      ST_WAIT:   if (cnt != '0) cnt_n = cnt - 5'd1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start   <= 1'b1;
      grant   <= '0;
      message <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      start   <= start_n;
      grant   <= grant_n;
      message <= msg_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `sender` UART transmitter (10-bit frame, one bit per CLK) between `N_REQ` byte producers. It arbitrates pending requests, latches the winning byte onto `message`, and generates the falling edge on `start` that launches the frame. It then holds the transmitter reserved until the frame plus a configurable idle gap has left `TX`. It sits directly in front of `sender` and is the only block that drives its `start`/`message` inputs.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `GAP`, default 1: extra idle-high (stop-level) bit times inserted between consecutive frames, 0..15.

- `CLK`  in  1: clock, same clock as `sender` (500 kHz, one bit time per cycle).
- `RST`  in  1: reset. One clock; reset is asynchronous and active-high.
- `req`  in  N_REQ: `req[i]` high = requester i has a byte pending. Level; held until granted.
- `data`  in  8*N_REQ: byte of requester i at `data[8*i+7:8*i]`. Stable while `req[i]` is high.
- `grant`  out  N_REQ: one-cycle one-hot pulse; byte of that requester was captured.
- `busy`  out  1: high whenever the state is not IDLE.
- `start`  out  1: to `sender.start`; idles high, low for exactly one cycle per frame.
- `message`  out  8 (`[8:1]`): to `sender.message`; holds the captured byte.

## Operation
- States: IDLE, LAUNCH, WAIT.
- IDLE: if any `req` bit is high, select winner w by round-robin from pointer `ptr`. The lowest index ≥ `ptr` wins, wrapping to 0. On the clock edge: `message <= data[w]`, `start <= 0`, `grant[w] <= 1`, `ptr <= (w+1) mod N_REQ`, go to LAUNCH. With no requests, stay in IDLE.
- LAUNCH (exactly 1 cycle): `start` is low and `grant[w]` is high. On the edge: `start <= 1`, `grant <= 0`, `cnt <= 7+GAP`, go to WAIT.
- WAIT: decrement `cnt`. When `cnt == 0`, go to IDLE. `message` is not changed.
- Requests seen during LAUNCH/WAIT are ignored, not queued. A requester that drops `req` before being granted is simply skipped.
- `cnt` is 5 bits and must never underflow.
- Reset values: state IDLE, `start` 1, `message` 0, `grant` 0, `busy` 0, `ptr` 0, `cnt` 0.
- Reset mid-frame: outputs return to their reset values immediately. `sender` has no reset, so the frame already loaded into its shift register still completes on `TX`. Only reset at a frame boundary is supported for clean output.

## Timing
- Let IDLE decide in cycle t. Then:
  - cycle t+1: `start` is low and `grant` is high.
  - cycle t+2: `sender` internal set is high.
  - edge ending t+2: `sender` loads the frame.
  - `TX`: start bit in t+3, data bits LSB-first in t+4..t+11, stop bit in t+12.
- WAIT occupies cycles t+2..t+9+GAP. IDLE is re-entered at t+10+GAP.
- A back-to-back next frame therefore has its start bit at t+13+GAP: exactly GAP idle-high bit times after the stop bit. The launch latency of 3 cycles matches the re-entry lead of 3 cycles.
- Frame period under continuous requests: 10+GAP cycles. `busy` is high for 9+GAP cycles out of each period.
- `message` must stay stable from t+1 through the load edge ending t+2. This is guaranteed because it changes only in IDLE.

## Structure
- Shared package `uart_pkg` holds:
  - `FRAME_BITS = 10`
  - `LAUNCH_LAT = 3` (decision to start bit)
  - the state encoding
  - the WAIT reload `7+GAP`, written as `FRAME_BITS - LAUNCH_LAT + GAP`
- Sub-module `rr_arbiter`: inputs `req`, `ptr`; outputs one-hot `win` and `any`. It is combinational and parameterised by `N_REQ`. The FSM, counter and output registers stay in `uart_tx_sched`.
- Bench instantiates `uart_tx_sched` and `sender` together and decodes `TX`.

## Test plan
- Reset, then `req=0` for 20 cycles -> `start` stays 1, `grant` stays 0, `busy` stays 0, `TX` stays 1.
- `req[2]=1` with `data` byte 2 = 0xA5 from cycle 0 -> `grant=4'b0100` in cycle 1 only, start bit on `TX` at cycle 3, decoded byte 0xA5, `busy` falls at cycle 10+GAP.
- All four `req` held high, bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0. Frames are 10+GAP cycles apart, with exactly GAP high bits between stop and start.
- `GAP=0`, `req[0]` held continuously with 0xFF then 0x00 -> contiguous frames on `TX`, no missing or extra bit.
- `req[1]` asserted during WAIT then dropped before IDLE -> no grant to requester 1; the next `req[3]` is served normally.
- `RST` asserted in LAUNCH -> `start` is 1, `grant`/`busy`/`message` are 0 immediately. After release, a new request completes normally once `TX` has been idle for 10 cycles.
